rpg_uart_tx: RTL and testbench

//   8N1 UART transmitter driving the reprogram link's host-bound line (RPG_TX), replacing the constant-1 tie-off.

---
 rtl/rpg_uart_tx.sv | 202 ++++++++++++++++++++
 tb/tb_rpg_uart_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpg_uart_tx.sv
// 8N1 UART transmitter for the reprogram link's host-bound line.
// Byte FIFO feeds a serialiser; a report sequencer injects a 4-byte status frame.
module rpg_uart_tx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_50mhz,
  input  logic        rstn,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        wr_ready,
  input  logic        rpt_req,
  input  logic [7:0]  rpt_xorc,
  input  logic [15:0] rpt_count,
  output logic        rpt_busy,
  output logic        tx_busy,
  output logic        tx
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned PW1 = PW + 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_PUSH} rpt_state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, occ;
  logic          full, empty, user_push, frame_push, push, pop;
  logic [7:0]    push_data, frame_byte, head;

  tx_state_t     tstate, tstate_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n, tick;

  rpt_state_t    rstate, rstate_n;
  logic [1:0]    ridx, ridx_n;
  logic [7:0]    lat_xorc;
  logic [15:0]   lat_count;
  logic [PW:0]   occ_after;
  logic          room;

  assign occ       = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rpt_busy  = (rstate != R_IDLE);
  assign wr_ready  = !full && !rpt_busy;
  assign user_push = wr_en && wr_ready;
  assign push      = user_push || frame_push;
  assign push_data = frame_push ? frame_byte : wr_data;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign tx_busy   = !empty || (tstate != T_IDLE);

  // Free space is judged after any user byte accepted in the same cycle.
  assign occ_after = PW1'(occ) + PW1'(user_push);
  assign room      = (occ_after <= PW1'(FIFO_DEPTH - 4));

  // FIFO storage
  always_ff @(posedge clk_50mhz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers
  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Report sequencer registers
  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn) begin
      rstate    <= R_IDLE;
      ridx      <= '0;
      lat_xorc  <= '0;
      lat_count <= '0;
    end else begin
      rstate <= rstate_n;
      ridx   <= ridx_n;
      if (rpt_req && rstate == R_IDLE) begin
        lat_xorc  <= rpt_xorc;
        lat_count <= rpt_count;
      end
    end
  end

  // Report sequencer next state: wait for 4 free slots, then push 4 bytes
  always_comb begin
    rstate_n   = rstate;
    ridx_n     = ridx;
    frame_push = 1'b0;
    case (ridx)
      2'd0:    frame_byte = 8'h5A;
      2'd1:    frame_byte = lat_xorc;
      2'd2:    frame_byte = lat_count[15:8];
      default: frame_byte = lat_count[7:0];
    endcase
    case (rstate)
      R_IDLE: begin
        if (rpt_req) begin
          rstate_n = room ? R_PUSH : R_WAIT;
          ridx_n   = '0;
        end
      end
      R_WAIT: begin
        if (room) rstate_n = R_PUSH;
      end
      R_PUSH: begin
        frame_push = 1'b1;
        if (ridx == 2'd3) rstate_n = R_IDLE;
        else              ridx_n   = ridx + 2'd1;
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // Serialiser registers; tx follows the state one cycle later
  always_ff @(posedge clk_50mhz or negedge rstn) begin
    if (!rstn) begin
      tstate   <= T_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      tstate   <= tstate_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  assign tick = (baud_cnt == CW'(DIV - 1));

  // Serialiser next state
  always_comb begin
    tstate_n   = tstate;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    tx_n       = 1'b1;
    case (tstate)
      T_IDLE: begin
        baud_cnt_n = '0;
        bit_idx_n  = '0;
        if (!empty) begin
          pop      = 1'b1;
          shreg_n  = head;
          tstate_n = T_START;
        end
      end
      T_START: begin
        tx_n = 1'b0;
        if (tick) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tstate_n   = T_DATA;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      T_DATA: begin
        tx_n = shreg[0];
        if (tick) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) tstate_n  = T_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      T_STOP: begin
        if (tick) begin
          baud_cnt_n = '0;
          if (!empty) begin
            pop      = 1'b1;
            shreg_n  = head;
            tstate_n = T_START;
          end else begin
            tstate_n = T_IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
      default: tstate_n = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpg_uart_tx.sv
// Bench for rpg_uart_tx: a line decoder recovers bytes from tx and compares them
// with the byte stream the bench expects from its writes and report requests.
module tb_rpg_uart_tx;

  localparam int DIV  = 10;
  localparam int CHAR = 10 * DIV;
  localparam int DDIV = 50000000 / 115200;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  wr_data = '0;
  logic        wr_en = 1'b0, rpt_req = 1'b0;
  logic [7:0]  rpt_xorc = '0;
  logic [15:0] rpt_count = '0;
  logic        wr_ready, rpt_busy, tx_busy, tx;

  logic [7:0]  d_wr_data = '0;
  logic        d_wr_en = 1'b0;
  logic        d_wr_ready, d_rpt_busy, d_tx_busy, d_tx;

  rpg_uart_tx #(.CLK_HZ(1000000), .BAUD(100000), .FIFO_DEPTH(16)) dut (
    .clk_50mhz(clk), .rstn(rstn), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .rpt_req(rpt_req), .rpt_xorc(rpt_xorc), .rpt_count(rpt_count), .rpt_busy(rpt_busy),
    .tx_busy(tx_busy), .tx(tx));

  rpg_uart_tx dut_def (
    .clk_50mhz(clk), .rstn(rstn), .wr_data(d_wr_data), .wr_en(d_wr_en), .wr_ready(d_wr_ready),
    .rpt_req(1'b0), .rpt_xorc(8'h00), .rpt_count(16'h0000), .rpt_busy(d_rpt_busy),
    .tx_busy(d_tx_busy), .tx(d_tx));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  // Line decoder: mid-bit sampling; characters overlapping reset are discarded
  initial begin : line_mon
    logic [7:0] b;
    int st;
    bit abort;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        st = cyc; abort = 1'b0; b = '0;
        repeat (DIV / 2) begin @(negedge clk); if (rstn !== 1'b1) abort = 1'b1; end
        if (tx !== 1'b0) abort = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) begin @(negedge clk); if (rstn !== 1'b1) abort = 1'b1; end
          b[i] = tx;
        end
        repeat (DIV) begin @(negedge clk); if (rstn !== 1'b1) abort = 1'b1; end
        if (tx !== 1'b1) abort = 1'b1;
        if (!abort) begin rx_q.push_back(b); rx_t.push_back(st); end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Expected line level k cycles after the accepting edge for a lone character
  function automatic logic exp_line(int k, logic [7:0] d, int div);
    int b;
    if (k < 3 || k >= 3 + 10 * div) return 1'b1;
    b = (k - 3) / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic clear_q();
    exp_q.delete(); rx_q.delete(); rx_t.delete();
  endtask

  task automatic push_byte(input logic [7:0] d, input bit accept);
    wr_data = d; wr_en = 1'b1;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (tx_busy === 1'b1 && n < 40 * CHAR) begin @(negedge clk); n++; end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL drain tx_busy got %b exp 0", tx_busy); end
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
    checks++; if (wr_ready !== 1'b1)  begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    checks++; if (rpt_busy !== 1'b0)  begin errors++; $display("FAIL reset_rpt_busy got %b exp 0", rpt_busy); end
    checks++; if (tx_busy !== 1'b0)   begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
    checks++; if (d_tx !== 1'b1)      begin errors++; $display("FAIL reset_def_tx got %b exp 1", d_tx); end
    checks++; if (d_tx_busy !== 1'b0) begin errors++; $display("FAIL reset_def_tx_busy got %b exp 0", d_tx_busy); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_default();
    logic [7:0] d;
    int bad_tx = 0, bad_busy = 0, first_tx = -1, first_busy = -1;
    logic tx_k2 = 1'bx, tx_k3 = 1'bx;
    d = 8'h55;
    d_wr_data = d; d_wr_en = 1'b1;
    @(negedge clk);
    d_wr_en = 1'b0;
    for (int k = 1; k <= 10 * DDIV + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) tx_k2 = d_tx;
      if (k == 3) tx_k3 = d_tx;
      if (d_tx !== exp_line(k, d, DDIV)) begin bad_tx++; if (first_tx < 0) first_tx = k; end
      if (d_tx_busy !== (k <= 10 * DDIV + 1)) begin bad_busy++; if (first_busy < 0) first_busy = k; end
    end
    checks++; if (tx_k2 !== 1'b1) begin errors++; $display("FAIL def_latency_k2 got %b exp 1", tx_k2); end
    checks++; if (tx_k3 !== 1'b0) begin errors++; $display("FAIL def_latency_k3 got %b exp 0", tx_k3); end
    checks++;
    if (bad_tx !== 0) begin errors++; $display("FAIL def_waveform bad samples %0d first at %0d exp 0", bad_tx, first_tx); end
    checks++;
    if (bad_busy !== 0) begin errors++; $display("FAIL def_tx_busy bad samples %0d first at %0d exp 0", bad_busy, first_busy); end
  endtask

  task automatic test_bit_period();
    int t[$];
    logic prev;
    clear_q();
    push_byte(8'h55, 1'b1);
    prev = 1'b1;
    for (int k = 1; k <= 12 * DIV; k++) begin
      if (k > 1) @(negedge clk);
      if (tx !== prev) begin t.push_back(k); prev = tx; end
    end
    checks++;
    if (t.size() != 10) begin errors++; $display("FAIL period_edges got %0d exp 10", t.size()); end
    for (int i = 1; i < t.size(); i++) begin
      checks++;
      if (t[i] - t[i-1] != DIV) begin errors++; $display("FAIL period_bit%0d got %0d exp %0d", i, t[i] - t[i-1], DIV); end
    end
    drain();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL period_byte got %0d bytes exp 1 byte 55", rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (wr_ready !== (i < 17)) begin errors++; $display("FAIL b2b_wr_ready write %0d got %b exp %b", i, wr_ready, (i < 17)); end
      push_byte(8'($urandom), i < 17);
    end
    drain();
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < rx_t.size(); i++) begin
      checks++;
      if (rx_t[i] - rx_t[i-1] != CHAR) begin errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, rx_t[i] - rx_t[i-1], CHAR); end
    end
  endtask

  task automatic test_report(input logic [7:0] x, input logic [15:0] c);
    clear_q();
    checks++; if (rpt_busy !== 1'b0) begin errors++; $display("FAIL rpt_idle got %b exp 0", rpt_busy); end
    rpt_req = 1'b1; rpt_xorc = x; rpt_count = c;
    exp_q.push_back(8'h5A); exp_q.push_back(x); exp_q.push_back(c[15:8]); exp_q.push_back(c[7:0]);
    @(negedge clk);
    rpt_req = 1'b0; rpt_xorc = 8'($urandom); rpt_count = 16'($urandom);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (rpt_busy !== 1'b1) begin errors++; $display("FAIL rpt_busy k%0d got %b exp 1", k, rpt_busy); end
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rpt_wr_ready k%0d got %b exp 0", k, wr_ready); end
      push_byte(8'($urandom), 1'b0);
    end
    repeat (4) @(negedge clk);
    checks++; if (rpt_busy !== 1'b0) begin errors++; $display("FAIL rpt_done got %b exp 0", rpt_busy); end
    drain();
    checks++;
    if (rx_q.size() != 4) begin errors++; $display("FAIL rpt_count_bytes got %0d exp 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rpt_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_report_pending();
    logic [7:0] x;
    logic [15:0] c;
    int n = 0;
    clear_q();
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL pend_fill write %0d got %b exp 1", i, wr_ready); end
      push_byte(8'($urandom), 1'b1);
    end
    x = 8'($urandom); c = 16'($urandom);
    rpt_req = 1'b1; rpt_xorc = x; rpt_count = c;
    exp_q.push_back(8'h5A); exp_q.push_back(x); exp_q.push_back(c[15:8]); exp_q.push_back(c[7:0]);
    @(negedge clk);
    rpt_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rpt_busy !== 1'b1) begin errors++; $display("FAIL pend_busy_early got %b exp 1", rpt_busy); end
    repeat (115) @(negedge clk);
    checks++; if (rpt_busy !== 1'b1) begin errors++; $display("FAIL pend_busy_one_pop got %b exp 1", rpt_busy); end
    while (rpt_busy === 1'b1 && n < 3 * CHAR) begin @(negedge clk); n++; end
    checks++; if (rpt_busy !== 1'b0) begin errors++; $display("FAIL pend_busy_release got %b exp 0", rpt_busy); end
    drain();
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL pend_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL pend_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    clear_q();
    push_byte(8'h00, 1'b1);
    push_byte(8'($urandom), 1'b1);
    push_byte(8'($urandom), 1'b1);
    repeat (DIV + 35) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL rst_mid_tx_busy got %b exp 0", tx_busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_wr_ready got %b exp 1", wr_ready); end
    checks++; if (rpt_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_rpt_busy got %b exp 0", rpt_busy); end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet bad samples %0d exp 0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rst_mid_stale got %0d bytes exp 0", rx_q.size()); end
    clear_q();
    push_byte(8'($urandom), 1'b1);
    drain();
    checks++;
    if (rx_q.size() != 1) begin errors++; $display("FAIL rst_mid_after_count got %0d exp 1", rx_q.size()); end
    else begin
      checks++;
      if (rx_q[0] !== exp_q[0]) begin errors++; $display("FAIL rst_mid_after_byte got %h exp %h", rx_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_random_gaps();
    clear_q();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_ready !== 1'b1) begin errors++; $display("FAIL gaps_wr_ready write %0d got %b exp 1", i, wr_ready); end
      push_byte(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2 * CHAR)) @(negedge clk);
    end
    drain();
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps_count got %0d exp %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_byte%0d got %h exp %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_default();
    test_bit_period();
    test_back_to_back();
    test_report(8'h3C, 16'h0123);
    test_report(8'($urandom), 16'($urandom));
    test_report_pending();
    test_reset_mid();
    test_random_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
